// File: rtl/text_render_core.sv
// rtl/text_render_core.sv - parametrised single-clock colour text-mode renderer
//
// Ports:
//   i_clk, i_rst_n        pixel clock, synchronous active-low reset
//   i_wr_valid/o_wr_ready cell write handshake (accepted when both high)
//   i_wr_addr, i_wr_data  {row, col} and {attr[7:0], char[7:0]}
//   i_blink_en            1: attr[7] is blink, 0: attr[7] is bg intensity
//   o_font_addr           {char, glyph_y, glyph_x} to a registered font ROM
//   i_font_bit            ROM pixel, valid one clock after o_font_addr
//   o_r/o_g/o_b           RGB565 pixel, forced to zero outside active video
//   o_hsync/o_vsync/o_de  timing outputs, polarity set by SYNC_POL
//   o_frame_start         one-clock pulse with the first pixel of each frame
//   i_cur_row/i_cur_col   underline cursor cell (only with TEXT_RENDER_CURSOR_EN)
//
// Optional feature macro: TEXT_RENDER_CURSOR_EN

module text_render_core #(
  parameter int          H_ACTIVE     = 480,
  parameter int          H_FP         = 2,
  parameter int          H_SYNC       = 41,
  parameter int          H_BP         = 2,
  parameter int          V_ACTIVE     = 272,
  parameter int          V_FP         = 2,
  parameter int          V_SYNC       = 10,
  parameter int          V_BP         = 2,
  parameter int          SYNC_POL     = 0,
  parameter int          FONT_W_LOG2  = 3,
  parameter int          FONT_H_LOG2  = 4,
  parameter int          COL_BITS     = 6,
  parameter int          ROW_BITS     = 5,
  parameter int          BLINK_FRAMES = 16,
  parameter logic [15:0] CLEAR_WORD   = 16'h0720
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_wr_valid,
  output logic                                  o_wr_ready,
  input  logic [ROW_BITS+COL_BITS-1:0]          i_wr_addr,
  input  logic [15:0]                           i_wr_data,
  input  logic                                  i_blink_en,
`ifdef TEXT_RENDER_CURSOR_EN
  input  logic [ROW_BITS-1:0]                   i_cur_row,
  input  logic [COL_BITS-1:0]                   i_cur_col,
`endif
  output logic [8+FONT_H_LOG2+FONT_W_LOG2-1:0]  o_font_addr,
  input  logic                                  i_font_bit,
  output logic [4:0]                            o_r,
  output logic [5:0]                            o_g,
  output logic [4:0]                            o_b,
  output logic                                  o_hsync,
  output logic                                  o_vsync,
  output logic                                  o_de,
  output logic                                  o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int AW      = ROW_BITS + COL_BITS;
  localparam int NCOLS   = 1 << COL_BITS;
  localparam int NROWS   = 1 << ROW_BITS;
  localparam int BCW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                 state;
  logic [AW-1:0]          clr_addr;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [BCW-1:0]         blink_cnt;
  logic                   blink_on;

  // stage 0 (combinational from the counters)
  int                     xi, yi;
  logic [AW-1:0]          rd_addr;
  logic [FONT_W_LOG2-1:0] gx0;
  logic [FONT_H_LOG2-1:0] gy0;
  logic                   de0, hs0, vs0, fs0, cur0;

  // stage 1
  logic [15:0]            rd_data;
  logic [FONT_W_LOG2-1:0] gx1;
  logic [FONT_H_LOG2-1:0] gy1;
  logic                   de1, hs1, vs1, fs1, cur1;

  // stage 2
  logic [7:0]             attr2;
  logic                   de2, hs2, vs2, fs2, cur2;

  // RAM write port
  logic                   we;
  logic [AW-1:0]          wa;
  logic [15:0]            wd;
  logic [15:0]            mem [0:(1<<AW)-1];

  // pixel colour selection
  logic                   use_fg;
  logic                   bg_i;
  logic [3:0]             pix;

  function automatic logic [4:0] lvl5(input logic c, input logic i);
    return c ? (i ? 5'd31 : 5'd21) : (i ? 5'd10 : 5'd0);
  endfunction

  function automatic logic [5:0] lvl6(input logic c, input logic i);
    return c ? (i ? 6'd63 : 6'd42) : (i ? 6'd21 : 6'd0);
  endfunction

  // Raster counters run in both CLEAR and RUN so syncs are always valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x == XW'(H_TOTAL - 1)) begin
      x <= '0;
      y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  // Power-up clear sweeps every cell once, then the write port opens.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      o_wr_ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) begin
        state      <= ST_RUN;
        o_wr_ready <= 1'b1;
      end
    end
  end

  // Blink phase advances at the raster frame start, two clocks before the
  // first pixel reaches stage 3, so a whole frame sees one phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (fs0) begin
      if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    xi      = int'(x);
    yi      = int'(y);
    gx0     = x[FONT_W_LOG2-1:0];
    gy0     = y[FONT_H_LOG2-1:0];
    // cell coordinates wrap at the RAM width, also in the blanking area
    rd_addr = AW'((((yi >> FONT_H_LOG2) & (NROWS - 1)) * NCOLS) +
                  ((xi >> FONT_W_LOG2) & (NCOLS - 1)));
    de0     = (xi < H_ACTIVE) && (yi < V_ACTIVE) && (state == ST_RUN);
    hs0     = (xi >= H_ACTIVE + H_FP) && (xi < H_ACTIVE + H_FP + H_SYNC);
    vs0     = (yi >= V_ACTIVE + V_FP) && (yi < V_ACTIVE + V_FP + V_SYNC);
    fs0     = (xi == 0) && (yi == 0);
`ifdef TEXT_RENDER_CURSOR_EN
    cur0    = (rd_addr == {i_cur_row, i_cur_col}) &&
              (gy0 >= FONT_H_LOG2'((1 << FONT_H_LOG2) - 2));
`else
    cur0    = 1'b0;
`endif
  end

  always_comb begin
    we = 1'b0;
    wa = i_wr_addr;
    wd = i_wr_data;
    if (state == ST_CLEAR) begin
      we = i_rst_n;
      wa = clr_addr;
      wd = CLEAR_WORD;
    end else begin
      // a request coinciding with reset is dropped even though ready is high
      we = i_rst_n & i_wr_valid & o_wr_ready;
    end
  end

  // Single-port style RAM; non-blocking read gives read-first behaviour.
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gx1 <= '0;
      gy1 <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      fs1 <= 1'b0;
      cur1 <= 1'b0;
      attr2 <= '0;
      de2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      fs2 <= 1'b0;
      cur2 <= 1'b0;
    end else begin
      gx1   <= gx0;
      gy1   <= gy0;
      de1   <= de0;
      hs1   <= hs0;
      vs1   <= vs0;
      fs1   <= fs0;
      cur1  <= cur0;
      attr2 <= rd_data[15:8];
      de2   <= de1;
      hs2   <= hs1;
      vs2   <= vs1;
      fs2   <= fs1;
      cur2  <= cur1;
    end
  end

  assign o_font_addr = {rd_data[7:0], gy1, gx1};

  always_comb begin
    bg_i   = i_blink_en ? 1'b0 : attr2[7];
    use_fg = i_font_bit & ~(i_blink_en & attr2[7] & ~blink_on);
    if (cur2 && blink_on) begin
      use_fg = 1'b1;
    end
    pix = use_fg ? attr2[3:0] : {bg_i, attr2[6:4]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_de          <= 1'b0;
      o_hsync       <= ~SYNC_ACT;
      o_vsync       <= ~SYNC_ACT;
      o_frame_start <= 1'b0;
    end else begin
      o_r           <= de2 ? lvl5(pix[2], pix[3]) : 5'd0;
      o_g           <= de2 ? lvl6(pix[1], pix[3]) : 6'd0;
      o_b           <= de2 ? lvl5(pix[0], pix[3]) : 5'd0;
      o_de          <= de2;
      o_hsync       <= hs2 ? SYNC_ACT : ~SYNC_ACT;
      o_vsync       <= vs2 ? SYNC_ACT : ~SYNC_ACT;
      o_frame_start <= fs2;
    end
  end

endmodule

// File: doc/text_render_core.md
Name: text_render_core

Overview:
- Parametrised successor to the fixed 480x272, 8x16 colour text-mode top.
- Fully synchronous single-clock text renderer: internal H/V timing, inferred character/attribute RAM with handshaked write port, power-up clear FSM, external font-ROM interface, IRGB colour expansion with frame-counted blink.
- Sits between the LCD pixel-clock PLL and the LCD pins. A CPU/UART writer fills the screen through the write port.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, hsync width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vsync width (lines)
- V_BP, 2, vertical back porch (lines)
- SYNC_POL, 0, 0 = active-low syncs, 1 = active-high
- FONT_W_LOG2, 3, glyph width = 2^n pixels
- FONT_H_LOG2, 4, glyph height = 2^n lines
- COL_BITS, 6, RAM column address bits
- ROW_BITS, 5, RAM row address bits
- BLINK_FRAMES, 16, frames per blink phase toggle
- CLEAR_WORD, 16'h0720, word written to every cell by the clear FSM (attr 07, char 20)

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous active-low reset
- i_wr_valid  in  1  write request
- o_wr_ready  out  1  write accepted when valid & ready
- i_wr_addr  in  ROW_BITS+COL_BITS  {row, col}
- i_wr_data  in  16  {attr[7:0], char[7:0]}
- i_blink_en  in  1  1: attr[7] = blink; 0: attr[7] = background intensity
- o_font_addr  out  8+FONT_H_LOG2+FONT_W_LOG2  {char, glyph_y, glyph_x}
- i_font_bit  in  1  ROM pixel; registered ROM, valid 1 clock after o_font_addr
- o_r  out  5  red
- o_g  out  6  green
- o_b  out  5  blue
- o_hsync  out  1  hsync
- o_vsync  out  1  vsync
- o_de  out  1  data enable
- o_frame_start  out  1  1-clock pulse, aligned with the first pixel of each frame at the pins

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - counters x=y=0
  - o_hsync/o_vsync inactive (~SYNC_POL)
  - o_de=0, RGB=0, o_frame_start=0, o_wr_ready=0
  - blink counter=0, blink phase=on
  - FSM → CLEAR
- Reset mid-frame or mid-clear restarts everything identically.
- Timing:
  - x counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters.
  - y advances when x wraps; V_TOTAL likewise.
  - Active region: x<H_ACTIVE and y<V_ACTIVE.
  - hsync active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync active for the analogous y range, for whole lines.
- Pipeline, stage t = counter value:
  - t+1: RAM read data valid; o_font_addr driven combinationally from it plus glyph_x/glyph_y delayed 1.
  - t+2: i_font_bit and attribute (delayed 1) valid.
  - t+3: RGB/sync/DE/frame_start registered at the pins.
  - Total latency 3 clocks; sync, DE and RGB mutually aligned.
- Cell address = {y>>FONT_H_LOG2, x>>FONT_W_LOG2}, truncated to RAM width.
- RGB=0 whenever the delayed DE is 0.
- FSM CLEAR:
  - Writes CLEAR_WORD to addresses 0..2^(ROW_BITS+COL_BITS)-1, one per clock.
  - o_wr_ready=0 throughout; o_de=0.
  - Then → RUN.
- FSM RUN:
  - o_wr_ready=1 every cycle.
  - Accepted write visible to reads from the next clock.
  - Same-address simultaneous read returns old data (read-first).
  - Timing counters run during CLEAR; syncs are valid in both states.
- Colour, attr = {bg[3:0]=IRGB, fg[3:0]=IRGB}:
  - 5-bit channel = c ? (i ? 31 : 21) : (i ? 10 : 0).
  - 6-bit green = c ? (i ? 63 : 42) : (i ? 21 : 0).
  - Pixel uses fg if font bit=1, else bg.
- Blink:
  - Counter increments at each frame start.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles the phase: period = BLINK_FRAMES frames per phase.
  - With i_blink_en=1: bg intensity forced 0. If attr[7]=1 and phase=off, fg pixels are drawn in bg colour.
  - With i_blink_en=0: attr[7] is bg intensity and there is no blink.

Optional Feature:
- Macro: TEXT_RENDER_CURSOR_EN.
- Defined:
  - Adds inputs i_cur_row (ROW_BITS) and i_cur_col (COL_BITS).
  - Underline cursor on glyph lines 2^FONT_H_LOG2-2 and 2^FONT_H_LOG2-1 of that cell.
  - Drawn in the cell's fg colour during blink phase=on, independent of i_blink_en.
  - Pipeline-aligned; no latency change.
- Undefined: ports absent, no cursor logic.

Test Plan:
- Reset released → o_wr_ready=0 for exactly 2048 clocks (default) then 1. Reading any cell after CLEAR yields char 0x20, attr 0x07.
- Free run, defaults → H_TOTAL=525, V_TOTAL=286. hsync low 41 clocks starting 3 clocks after counter x=482. o_frame_start period = 150150 clocks.
- Write {attr 0x1E, char 0x41} to addr {row 2, col 5} → o_font_addr = {0x41, gy, gx} for x 40..47, y 32..47. With i_font_bit=1, pins show R=31, G=63, B=0 (yellow); with bit=0, B=21 (blue).
- attr 0x8F, i_blink_en=1 → fg alternates white/black every 16 frames. With i_blink_en=0 → bg = dark grey (10,21,10), steady.
- Write issued on the clock reset asserts, and again mid-CLEAR → not accepted. Cell stays 0x0720.
- TEXT_RENDER_CURSOR_EN, cursor at (0,0) → glyph lines 14–15 of cell 0 show fg colour only during phase=on.
